// File: rtl/mips_ctrl_pkg.sv
// Purpose: shared encodings for the multicycle MIPS control unit (states, opcodes, mux selects).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_ctrl_pkg;

  // Controller state encoding; codes 12-15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // Supported instr[31:26] values.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // ALU operation select.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select.
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // Next-PC select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state control word; PCWrite and Branch are combined into PCEn at the top.
  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  // True for every opcode the controller knows how to sequence.
  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Purpose: groups the controller's datapath-facing signals (opcode/zero in, controls out).
// Latency: n/a (wires only).
// Backpressure: none; the datapath always accepts the control word.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic       zero;
  logic       IorD;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       illegal_op;
  logic [3:0] state;

  // Controller side.
  modport master (
    input  opcode, zero,
    output IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, state
  );

  // Datapath side.
  modport slave (
    output opcode, zero,
    input  IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, state
  );
endinterface

// File: rtl/mc_outdec.sv
// Purpose: pure state-to-control-word decode (Moore outputs).
// Latency: combinational, zero cycles.
// Backpressure: none.
module mc_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  output ctrl_t      ctrl_o
);

  // Everything defaults to 0 so each state lists only what it asserts; unused codes stay all-zero.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.irwrite = 1'b1;
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.pcsrc   = PCSRC_ALU;
        ctrl_o.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = SRCB_IMMSH2;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_B;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_B;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.branch  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl_o.regwrite = 1'b1;
      end
      S_JEX: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: multicycle MIPS control FSM (state register, opcode latch, next-state, PCEn).
// Latency: lw 5, sw/R-type/addi 4, beq/j 3, illegal opcode 2 cycles.
// Backpressure: none; advances every clock, reset abandons the current instruction.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_controller_if.master   bus
);

  logic [3:0] state_q, state_d;
  logic [5:0] opcode_q;
  ctrl_t      ctrl;

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Opcode captured on the DECODE edge so later IR changes cannot steer MEMADR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  opcode_q <= '0;
    else if (state_q == S_DECODE) opcode_q <= bus.opcode;
  end

  // Next-state: DECODE dispatches on the live opcode, MEMADR on the latched one.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Write enables are held low while reset is asserted, since the reset state (FETCH) would
  // otherwise raise IRWrite and PCEn.
  always_comb begin
    bus.IorD       = ctrl.iord;
    bus.IRWrite    = ctrl.irwrite & rst_n;
    bus.MemWrite   = ctrl.memwrite & rst_n;
    bus.RegDst     = ctrl.regdst;
    bus.MemtoReg   = ctrl.memtoreg;
    bus.RegWrite   = ctrl.regwrite & rst_n;
    bus.ALUSrcA    = ctrl.alusrca;
    bus.ALUSrcB    = ctrl.alusrcb;
    bus.ALUOp      = ctrl.aluop;
    bus.PCSrc      = ctrl.pcsrc;
    bus.PCEn       = rst_n & (ctrl.pcwrite | (ctrl.branch & bus.zero));
    bus.illegal_op = rst_n & (state_q == S_DECODE) & ~is_supported(bus.opcode);
    bus.state      = state_q;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; all encodings SHALL come from the shared package.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  instr[31:26] from the instruction register, sampled in DECODE.
REQ-005 zero  in  1  ALU zero flag, used only in BEQEX.
REQ-006 IorD, IRWrite, MemWrite  out  1 each  memory address select (1 = ALUOut), IR load enable, memory write enable.
REQ-007 RegDst, MemtoReg, RegWrite  out  1 each  register-file write control.
REQ-008 ALUSrcA  out  1  (0 = PC, 1 = A); ALUSrcB  out  2  (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
REQ-009 ALUOp  out  2  (00 add, 01 sub, 10 funct-decoded); PCSrc  out  2  (00 ALUResult, 01 ALUOut, 10 jump target).
REQ-010 PCEn  out  1  PC write enable; illegal_op  out  1  one-cycle unsupported-opcode flag; state  out  4  current state, for debug.

Function
REQ-011 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-012 FETCH SHALL go to DECODE unconditionally and SHALL assert IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite=1.
REQ-013 DECODE SHALL branch on opcode: 00 to RTYPEEX, 23 or 2B to MEMADR, 04 to BEQEX, 08 to ADDIEX, 02 to JEX, any other value to FETCH. It SHALL assert ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-014 MEMADR SHALL go to MEMRD if the opcode latched at DECODE is 23, otherwise to MEMWR. It SHALL assert ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-015 MEMRD SHALL assert IorD=1 and go to MEMWB. MEMWB SHALL assert RegDst=0, MemtoReg=1, RegWrite=1 and go to FETCH.
REQ-016 MEMWR SHALL assert IorD=1, MemWrite=1 and go to FETCH.
REQ-017 RTYPEEX SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=10 and go to RTYPEWB. RTYPEWB SHALL assert RegDst=1, MemtoReg=0, RegWrite=1 and go to FETCH.
REQ-018 BEQEX SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 and go to FETCH.
REQ-019 ADDIEX SHALL assert ALUSrcA=1, ALUSrcB=10, ALUOp=00 and go to ADDIWB. ADDIWB SHALL assert RegDst=0, MemtoReg=0, RegWrite=1 and go to FETCH.
REQ-020 JEX SHALL assert PCSrc=10, PCWrite=1 and go to FETCH.
REQ-021 PCEn SHALL equal PCWrite OR (Branch AND zero), computed combinationally in the same cycle.
REQ-022 Any output not listed for a state SHALL be 0. Enables SHALL never be left undriven, and no output SHALL depend on opcode except through the state.
REQ-023 The opcode SHALL be latched into an internal register at the DECODE edge. The latched value SHALL steer MEMADR, so opcode changes after DECODE have no effect.
REQ-024 illegal_op SHALL be 1 for exactly the DECODE cycle in which opcode is unsupported. The next state SHALL be FETCH, which re-fetches at PC+4.
REQ-025 Unused state codes 12-15 SHALL drive all outputs to 0 and return to FETCH on the next edge.
REQ-026 Instruction latency SHALL be lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles, with illegal opcodes taking 2.

Reset
REQ-027 While rst_n=0, state SHALL be FETCH, the latched opcode SHALL be 0, and IRWrite, PCEn, RegWrite, MemWrite and illegal_op SHALL be forced to 0.
REQ-028 Release of rst_n SHALL take effect on the next rising clk, which begins FETCH.
REQ-029 Reset asserted mid-instruction SHALL abandon the instruction with no further write enable asserted.

Structure
REQ-030 Shared package mips_ctrl_pkg SHALL hold the state encoding, the opcode constants (RTYPE 00, LW 23, SW 2B, BEQ 04, ADDI 08, J 02), and the ALUOp, ALUSrcB and PCSrc encodings.
REQ-031 The state-to-outputs decode SHALL live in one combinational sub-module, mc_outdec. The top level SHALL hold the state register, the opcode latch, next-state logic and PCEn.

Verification
REQ-032 lw (opcode 23) from reset release: states 0,1,2,3,4,0, with RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-033 sw (2B): states 0,1,2,5,0, with MemWrite=1 only in MEMWR and RegWrite never 1.
REQ-034 beq (04): zero=1 gives PCEn=1 with PCSrc=01 in BEQEX; zero=0 gives PCEn=0 in BEQEX.
REQ-035 j (02) gives PCSrc=10 and PCEn=1 in JEX. Opcode 3F gives illegal_op=1 for one cycle, then FETCH.
REQ-036 rst_n pulled low in MEMWR (async, mid-cycle): MemWrite drops immediately, state reads 0, and after release the sequence resumes 0,1.
